// File: rtl/message_scroller_if.sv
// Bundles the message-scroller control, buffer-write and display signals.
// The master drives commands and writes; the slave (the scroller) returns the window and status.
interface message_scroller_if #(
    parameter int MSG_LEN    = 16,
    parameter int NUM_DIGITS = 6,
    parameter int CHAR_W     = 5
);
    localparam int AW = $clog2(MSG_LEN);
    localparam int LW = $clog2(MSG_LEN + 1);

    logic                         tick;
    logic                         wr_en;
    logic [AW-1:0]                wr_addr;
    logic [CHAR_W-1:0]            wr_data;
    logic [LW-1:0]                msg_len;
    logic                         start;
    logic                         stop;
    logic                         pause;
    logic                         dir;
    logic [NUM_DIGITS*CHAR_W-1:0] digits;
    logic                         busy;
    logic                         wrap;
    logic                         wr_ignored;

    modport master (
        output tick, wr_en, wr_addr, wr_data, msg_len, start, stop, pause, dir,
        input  digits, busy, wrap, wr_ignored
    );

    modport slave (
        input  tick, wr_en, wr_addr, wr_data, msg_len, start, stop, pause, dir,
        output digits, busy, wrap, wr_ignored
    );
endinterface

// File: rtl/message_scroller.sv
// Scrolls a NUM_DIGITS-wide window across a register-held message, one position per tick.
// The message is followed by NUM_DIGITS blanks so the text scrolls fully off before repeating.
module message_scroller #(
    parameter int                MSG_LEN    = 16,
    parameter int                NUM_DIGITS = 6,
    parameter int                CHAR_W     = 5,
    parameter logic [CHAR_W-1:0] BLANK_CODE = 5'h1F
) (
    input  logic                clk_in,
    input  logic                reset_n,
    message_scroller_if.slave   bus
);
    localparam int AW = $clog2(MSG_LEN);
    localparam int LW = $clog2(MSG_LEN + 1);
    localparam int PW = $clog2(MSG_LEN + NUM_DIGITS);
    localparam int SW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                       state, state_nx;
    logic [PW-1:0]                ptr, ptr_nx;
    logic [LW-1:0]                len_q, len_nx;
    logic [PW-1:0]                period;
    logic                         wrap_nx;
    logic                         ign_nx;
    logic                         wr_accept;
    logic [SW-1:0]                idx;
    logic [NUM_DIGITS*CHAR_W-1:0] digits_nx;
    logic [CHAR_W-1:0]            buffer [MSG_LEN];

    function automatic logic [SW-1:0] wrap_index(logic [SW-1:0] pos, logic [SW-1:0] per);
        return (pos >= per) ? pos - per : pos;
    endfunction

    assign period = PW'(len_q) + PW'(NUM_DIGITS);

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        len_nx    = len_q;
        wrap_nx   = 1'b0;
        ign_nx    = 1'b0;
        wr_accept = 1'b0;
        case (state)
            IDLE: begin
                if (bus.wr_en) begin
                    if (int'(bus.wr_addr) < MSG_LEN) wr_accept = 1'b1;
                    else                             ign_nx    = 1'b1;
                end
                if (!bus.stop && bus.start && bus.msg_len != '0) begin
                    state_nx = RUN;
                    ptr_nx   = '0;
                    len_nx   = (int'(bus.msg_len) > MSG_LEN) ? LW'(MSG_LEN) : bus.msg_len;
                end
            end
            RUN, HOLD: begin
                ign_nx = bus.wr_en;
                if (bus.stop) begin
                    state_nx = IDLE;
                    ptr_nx   = '0;
                end else if (state == RUN) begin
                    if (bus.pause) begin
                        state_nx = HOLD;
                    end else if (bus.tick) begin
                        if (!bus.dir) begin
                            if (ptr == period - PW'(1)) begin
                                ptr_nx  = '0;
                                wrap_nx = 1'b1;
                            end else begin
                                ptr_nx = ptr + PW'(1);
                            end
                        end else begin
                            if (ptr == '0) begin
                                ptr_nx  = period - PW'(1);
                                wrap_nx = 1'b1;
                            end else begin
                                ptr_nx = ptr - PW'(1);
                            end
                        end
                    end
                end else if (!bus.pause) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The window is built from next-state values so digits follow ptr with no extra delay.
    always_comb begin
        idx       = '0;
        digits_nx = {NUM_DIGITS{BLANK_CODE}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            idx = wrap_index(SW'(ptr_nx) + SW'(k), SW'(len_nx) + SW'(NUM_DIGITS));
            if (state_nx != IDLE && idx < SW'(len_nx))
                digits_nx[k*CHAR_W +: CHAR_W] = buffer[idx[AW-1:0]];
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ptr            <= '0;
            len_q          <= '0;
            for (int i = 0; i < MSG_LEN; i++) buffer[i] <= BLANK_CODE;
            bus.digits     <= {NUM_DIGITS{BLANK_CODE}};
            bus.busy       <= 1'b0;
            bus.wrap       <= 1'b0;
            bus.wr_ignored <= 1'b0;
        end else begin
            state          <= state_nx;
            ptr            <= ptr_nx;
            len_q          <= len_nx;
            if (wr_accept) buffer[bus.wr_addr] <= bus.wr_data;
            bus.digits     <= digits_nx;
            bus.busy       <= (state_nx != IDLE);
            bus.wrap       <= wrap_nx;
            bus.wr_ignored <= ign_nx;
        end
    end
endmodule

// File: tb/tb_message_scroller.sv
// Table-driven bench for message_scroller with a scoreboard queue of expected outputs.
// Expected windows come from a bench-side message model and modular stream indexing.
module tb_message_scroller;
    localparam int          ND    = 6;
    localparam logic [4:0]  B     = 5'h1F;
    localparam logic [29:0] ALL_B = {6{5'h1F}};

    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;

    message_scroller_if bus ();

    message_scroller dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       name;
        logic        tick, pause, stop, dir, start, wr_en;
        logic [4:0]  msg_len;
        logic [3:0]  wr_addr;
        logic [4:0]  wr_data;
        logic [29:0] digits;
        logic        busy, wrap, wr_ign;
    } vec_t;

    typedef struct {
        string       name;
        logic [29:0] digits;
        logic        busy, wrap, wr_ign;
    } exp_t;

    vec_t       vecs [$];
    exp_t       sb   [$];
    logic [4:0] model_buf [16];
    int         applied     = 0;
    int         miscompares = 0;

    function automatic logic [29:0] win(int p, int len);
        logic [29:0] d;
        int per;
        int id;
        per = len + ND;
        d   = '0;
        for (int k = 0; k < ND; k++) begin
            id = (p + k) % per;
            d[k*5 +: 5] = (id < len) ? model_buf[id] : B;
        end
        return d;
    endfunction

    function automatic vec_t mk(string n, logic tk, logic ps, logic sp, logic dr, logic st,
                                logic [4:0] ml, logic we, logic [3:0] wa, logic [4:0] wd,
                                logic [29:0] d, logic by, logic wp, logic wi);
        vec_t v;
        v.name = n;   v.tick = tk;   v.pause = ps;   v.stop = sp;   v.dir = dr;
        v.start = st; v.msg_len = ml; v.wr_en = we;  v.wr_addr = wa; v.wr_data = wd;
        v.digits = d; v.busy = by;   v.wrap = wp;    v.wr_ign = wi;
        return v;
    endfunction

    task automatic push_expect(string n, logic [29:0] d, logic by, logic wp, logic wi);
        exp_t e;
        e.name = n; e.digits = d; e.busy = by; e.wrap = wp; e.wr_ign = wi;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus.tick    = v.tick;
        bus.pause   = v.pause;
        bus.stop    = v.stop;
        bus.dir     = v.dir;
        bus.start   = v.start;
        bus.msg_len = v.msg_len;
        bus.wr_en   = v.wr_en;
        bus.wr_addr = v.wr_addr;
        bus.wr_data = v.wr_data;
        push_expect(v.name, v.digits, v.busy, v.wrap, v.wr_ign);
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            $display("[TB] FAIL scoreboard: got empty queue, want pending entry");
            miscompares++;
            return;
        end
        e = sb.pop_front();
        applied++;
        if (bus.digits !== e.digits) begin
            $display("[TB] FAIL %s.digits got %h want %h", e.name, bus.digits, e.digits);
            miscompares++;
        end
        if (bus.busy !== e.busy) begin
            $display("[TB] FAIL %s.busy got %b want %b", e.name, bus.busy, e.busy);
            miscompares++;
        end
        if (bus.wrap !== e.wrap) begin
            $display("[TB] FAIL %s.wrap got %b want %b", e.name, bus.wrap, e.wrap);
            miscompares++;
        end
        if (bus.wr_ignored !== e.wr_ign) begin
            $display("[TB] FAIL %s.wr_ignored got %b want %b", e.name, bus.wr_ignored, e.wr_ign);
            miscompares++;
        end
    endtask

    task automatic step(input vec_t v);
        apply_stimulus(v);
        @(posedge clk_in);
        #1;
        check_output();
    endtask

    initial begin
        int p;
        int len;
        bus.tick = 0; bus.pause = 0; bus.stop = 0; bus.dir = 0; bus.start = 0;
        bus.msg_len = '0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        for (int i = 0; i < 16; i++) model_buf[i] = B;

        // Vector table: expected values follow the message model as it is filled in.
        for (int i = 0; i < 4; i++) begin
            model_buf[i] = 5'(i + 1);
            vecs.push_back(mk($sformatf("write%0d", i), 0,0,0,0,0, 5'd0, 1, 4'(i), 5'(i + 1), ALL_B, 0,0,0));
        end
        p = 0; len = 4;
        vecs.push_back(mk("start4", 0,0,0,0,1, 5'd4, 0,4'd0,5'd0, win(p, len), 1,0,0));
        for (int t = 1; t <= 10; t++) begin
            p = (p + 1) % 10;
            vecs.push_back(mk($sformatf("left%0d", t), 1,0,0,0,0, 5'd0, 0,4'd0,5'd0, win(p, len), 1, (p == 0), 0));
        end
        p = 9;
        vecs.push_back(mk("right_wrap", 1,0,0,1,0, 5'd0, 0,4'd0,5'd0, win(p, len), 1,1,0));
        vecs.push_back(mk("no_tick",    0,0,0,1,0, 5'd0, 0,4'd0,5'd0, win(p, len), 1,0,0));
        vecs.push_back(mk("pause_tick", 1,1,0,0,0, 5'd0, 0,4'd0,5'd0, win(p, len), 1,0,0));
        vecs.push_back(mk("hold_tick",  1,1,0,0,0, 5'd0, 0,4'd0,5'd0, win(p, len), 1,0,0));
        vecs.push_back(mk("unpause",    0,0,0,0,0, 5'd0, 0,4'd0,5'd0, win(p, len), 1,0,0));
        p = 0;
        vecs.push_back(mk("left_wrap",  1,0,0,0,0, 5'd0, 0,4'd0,5'd0, win(p, len), 1,1,0));
        p = 1;
        vecs.push_back(mk("b2b_1",      1,0,0,0,0, 5'd0, 0,4'd0,5'd0, win(p, len), 1,0,0));
        p = 2;
        vecs.push_back(mk("b2b_2",      1,0,0,0,0, 5'd0, 0,4'd0,5'd0, win(p, len), 1,0,0));
        vecs.push_back(mk("wr_in_run",  0,0,0,0,0, 5'd0, 1,4'd0,5'd7, win(p, len), 1,0,1));
        vecs.push_back(mk("start_run",  0,0,0,0,1, 5'd2, 0,4'd0,5'd0, win(p, len), 1,0,0));
        vecs.push_back(mk("stop_tick",  1,1,1,0,0, 5'd0, 0,4'd0,5'd0, ALL_B, 0,0,0));
        p = 0;
        vecs.push_back(mk("restart4",   0,0,0,0,1, 5'd4, 0,4'd0,5'd0, win(p, len), 1,0,0));
        vecs.push_back(mk("stop2",      0,0,1,0,0, 5'd0, 0,4'd0,5'd0, ALL_B, 0,0,0));
        vecs.push_back(mk("start_len0", 0,0,0,0,1, 5'd0, 0,4'd0,5'd0, ALL_B, 0,0,0));
        for (int i = 4; i < 16; i++) begin
            model_buf[i] = 5'(i + 1);
            vecs.push_back(mk($sformatf("write%0d", i), 0,0,0,0,0, 5'd0, 1, 4'(i), 5'(i + 1), ALL_B, 0,0,0));
        end
        p = 0; len = 16;
        vecs.push_back(mk("start20",    0,0,0,0,1, 5'd20, 0,4'd0,5'd0, win(p, len), 1,0,0));
        for (int t = 1; t <= 7; t++) begin
            p = (p + 21) % 22;
            vecs.push_back(mk($sformatf("clamp_right%0d", t), 1,0,0,1,0, 5'd0, 0,4'd0,5'd0, win(p, len), 1, (t == 1), 0));
        end
        vecs.push_back(mk("stop3",      0,0,1,0,0, 5'd0, 0,4'd0,5'd0, ALL_B, 0,0,0));

        // Reset state, then run the table.
        #12;
        push_expect("reset", ALL_B, 0, 0, 0);
        check_output();
        reset_n = 1'b1;
        @(posedge clk_in);
        #1;
        foreach (vecs[i]) step(vecs[i]);

        // Asynchronous reset in mid-scroll clears outputs immediately and loses the message.
        len = 4;
        step(mk("pre_rst_start", 0,0,0,0,1, 5'd4, 0,4'd0,5'd0, win(0, len), 1,0,0));
        step(mk("pre_rst_tick",  1,0,0,0,0, 5'd0, 0,4'd0,5'd0, win(1, len), 1,0,0));
        bus.tick = 1'b0;
        #2;
        reset_n = 1'b0;
        push_expect("mid_reset", ALL_B, 0, 0, 0);
        #1;
        check_output();
        @(posedge clk_in);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) model_buf[i] = B;
        step(mk("post_rst_start", 0,0,0,0,1, 5'd4, 0,4'd0,5'd0, win(0, len), 1,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
